// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes and the
// controller FSM state encoding.
package alu_pkg;

  localparam logic [5:0] CTL_AND   = 6'b100100;
  localparam logic [5:0] CTL_OR    = 6'b100101;
  localparam logic [5:0] CTL_ADD   = 6'b100000;
  localparam logic [5:0] CTL_SUB   = 6'b100010;
  localparam logic [5:0] CTL_SLT   = 6'b101010;
  localparam logic [5:0] CTL_SRL   = 6'b000010;
  localparam logic [5:0] CTL_MULTU = 6'd25;
  localparam logic [5:0] CTL_MFHI  = 6'b010000;
  localparam logic [5:0] CTL_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/multu_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per step.
// hi/lo present the accumulator value as it will be after the current step.
module multu_seq #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // lo_reg doubles as the multiplier; its LSB selects the add each step.
  always_comb begin
    partial = {1'b0, hi_reg};
    if (lo_reg[0]) begin
      partial = {1'b0, hi_reg} + {1'b0, mcand_reg};
    end
    hi_next = partial[WIDTH:1];
    lo_next = {partial[0], lo_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      count_reg <= '0;
    end else if (load) begin
      mcand_reg <= a;
      hi_reg    <= '0;
      lo_reg    <= b;
      count_reg <= '0;
    end else if (step) begin
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign hi    = hi_next;
  assign lo    = lo_next;

endmodule

// File: rtl/seq_alu.sv
// Registered MIPS-subset ALU with single-cycle logic/arith ops and an
// iterative MULTU into HI/LO, plus a start/busy/done handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  state_t state_reg;
  state_t state_next;

  logic             alu_load;
  logic             mul_load;
  logic             mul_step;
  logic             mul_last;
  logic [SHW-1:0]   mul_count;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic             done_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic             slt_ovf;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  multu_seq #(.WIDTH(WIDTH)) u_multu (
    .clk   (clk),
    .rst   (rst),
    .load  (mul_load),
    .step  (mul_step),
    .a     (a),
    .b     (b),
    .count (mul_count),
    .hi    (mul_hi),
    .lo    (mul_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // start is only honoured in IDLE, so MUL and FIN silently drop it.
  always_comb begin
    state_next = state_reg;
    alu_load   = 1'b0;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    mul_last   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (ctl == CTL_MULTU) begin
            mul_load   = 1'b1;
            state_next = ST_MUL;
          end else begin
            alu_load = 1'b1;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_count == SHW'(WIDTH - 1)) begin
          mul_last   = 1'b1;
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    add_sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    slt_ovf    = (a[WIDTH-1] ^ b[WIDTH-1]) & (sub_sum[WIDTH-1] ^ a[WIDTH-1]);
    alu_result = '0;
    alu_carry  = 1'b0;
    case (ctl)
      CTL_AND:  alu_result = a & b;
      CTL_OR:   alu_result = a | b;
      CTL_ADD: begin
        alu_result = add_sum[WIDTH-1:0];
        alu_carry  = add_sum[WIDTH];
      end
      CTL_SUB: begin
        alu_result = sub_sum[WIDTH-1:0];
        alu_carry  = sub_sum[WIDTH];
      end
      CTL_SLT:  alu_result = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ slt_ovf};
      CTL_SRL:  alu_result = a >> b[SHW-1:0];
      CTL_MFHI: alu_result = hi_reg;
      CTL_MFLO: alu_result = lo_reg;
      default: begin
        alu_result = '0;
        alu_carry  = 1'b0;
      end
    endcase
  end

  // HI/LO take the final step's product directly, on the edge entering FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      carry_reg  <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      done_reg <= alu_load | mul_last;
      if (alu_load) begin
        result_reg <= alu_result;
        carry_reg  <= alu_carry;
      end
      if (mul_last) begin
        hi_reg <= mul_hi;
        lo_reg <= mul_lo;
      end
    end
  end

  assign result = result_reg;
  assign carry  = carry_reg;
  assign done   = done_reg;
  assign busy   = (state_reg != ST_IDLE);

endmodule
